// File: rtl/spi_slave_shift_register_pkg.sv
// Shared constants and edge-select encodings for the SPI slave.
// Character sizing defaults and sample/shift edge naming.
package spi_slave_shift_register_pkg;

  localparam int SPI_MAX_CHAR      = 32;
  localparam int SPI_CHAR_LEN_BITS = 5;

  typedef enum logic {
    EDGE_LEAD  = 1'b0,
    EDGE_TRAIL = 1'b1
  } edge_sel_e;

endpackage

// File: rtl/spi_slave_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin.
// Rise/fall strobes compare the synced level with one delayed copy.
module spi_slave_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              q_d;

  // shift the pin through the synchroniser and keep one delayed copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      q_d    <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      q_d    <= sync_q[STAGES-1];
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/spi_slave_shift_register.sv
// SPI slave shift engine, all logic on wb_clk_in.
// Macro SPI_SLAVE_OVERRUN_EN adds rx_ack, overrun_clr and overrun.
module spi_slave_shift_register
  import spi_slave_shift_register_pkg::*;
#(
  parameter int MAX_CHAR      = SPI_MAX_CHAR,
  parameter int CHAR_LEN_BITS = SPI_CHAR_LEN_BITS,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     wb_clk_in,
  input  logic                     wb_rst_n,
  input  logic                     enable,
  input  logic                     cpol,
  input  logic                     cpha,
  input  logic                     lsb,
  input  logic [CHAR_LEN_BITS-1:0] len,
  input  logic [MAX_CHAR-1:0]      tx_data,
  input  logic                     tx_load,
`ifdef SPI_SLAVE_OVERRUN_EN
  input  logic                     rx_ack,
  input  logic                     overrun_clr,
  output logic                     overrun,
`endif
  input  logic                     sclk,
  input  logic                     ss_n,
  input  logic                     mosi,
  output logic                     miso,
  output logic [MAX_CHAR-1:0]      rx_data,
  output logic                     rx_valid,
  output logic                     tx_ready,
  output logic                     busy
);

  localparam int NW = CHAR_LEN_BITS + 1;
  localparam int IW = $clog2(MAX_CHAR);

  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic ss_s, ss_rise_unused, ss_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  logic      lead, trail;
  logic      sample_edge, shift_edge;
  logic      last_bit, reload, done_q;
  edge_sel_e sample_sel;

  logic [NW-1:0]       n_len, cnt;
  logic [IW-1:0]       bit_idx, first_idx;
  logic [MAX_CHAR-1:0] rx_shift, rx_next;
  logic [MAX_CHAR-1:0] tx_shift, hold;

  spi_slave_sync_edge #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b0)
  ) u_sync_sclk (
    .clk  (wb_clk_in),
    .rst_n(wb_rst_n),
    .d    (sclk),
    .q    (sclk_lvl_unused),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_slave_sync_edge #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b1)
  ) u_sync_ss (
    .clk  (wb_clk_in),
    .rst_n(wb_rst_n),
    .d    (ss_n),
    .q    (ss_s),
    .rise (ss_rise_unused),
    .fall (ss_fall)
  );

  spi_slave_sync_edge #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b0)
  ) u_sync_mosi (
    .clk  (wb_clk_in),
    .rst_n(wb_rst_n),
    .d    (mosi),
    .q    (mosi_s),
    .rise (mosi_rise_unused),
    .fall (mosi_fall_unused)
  );

  assign lead  = cpol ? sclk_fall : sclk_rise;
  assign trail = cpol ? sclk_rise : sclk_fall;

  assign sample_sel  = cpha ? EDGE_TRAIL : EDGE_LEAD;
  assign sample_edge = (sample_sel == EDGE_TRAIL) ? trail : lead;
  assign shift_edge  = (sample_sel == EDGE_TRAIL) ? lead : trail;

  assign n_len     = {~|len, len};
  assign bit_idx   = IW'(lsb ? n_len - cnt : cnt - NW'(1));
  assign first_idx = IW'(lsb ? {NW{1'b0}} : n_len - NW'(1));
  assign last_bit  = (cnt == NW'(1));

  assign reload = enable & ~ss_s &
                  (ss_fall | (busy & sample_edge & last_bit));

  // insert the sampled bit and clear everything above the length
  always_comb begin
    rx_next          = rx_shift;
    rx_next[bit_idx] = mosi_s;
    for (int i = 0; i < MAX_CHAR; i++) begin
      if (i >= int'(n_len)) rx_next[i] = 1'b0;
    end
  end

  // character sequencing: start, sample, shift, complete, abort
  always_ff @(posedge wb_clk_in or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      busy     <= 1'b0;
      cnt      <= '0;
      miso     <= 1'b0;
      rx_shift <= '0;
      tx_shift <= '0;
      rx_data  <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!enable || ss_s) begin
        busy <= 1'b0;
        cnt  <= '0;
        miso <= 1'b0;
      end else if (ss_fall) begin
        busy     <= 1'b1;
        cnt      <= n_len;
        tx_shift <= hold;
        miso     <= hold[first_idx];
      end else if (busy && sample_edge) begin
        rx_shift <= rx_next;
        if (last_bit) begin
          rx_data  <= rx_next;
          done_q   <= 1'b1;
          cnt      <= n_len;
          tx_shift <= hold;
        end else begin
          cnt <= cnt - NW'(1);
        end
      end else if (busy && shift_edge) begin
        miso <= tx_shift[bit_idx];
      end
    end
  end

  // valid strobe trails the rx_data update by one cycle
  always_ff @(posedge wb_clk_in or negedge wb_rst_n) begin
    if (!wb_rst_n) rx_valid <= 1'b0;
    else           rx_valid <= done_q;
  end

  // holding register: last write wins, reload frees it
  always_ff @(posedge wb_clk_in or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      hold     <= '0;
      tx_ready <= 1'b1;
    end else if (tx_load) begin
      hold     <= tx_data;
      tx_ready <= 1'b0;
    end else if (reload) begin
      tx_ready <= 1'b1;
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  logic rx_pending;

  // flag a new word landing on an unacknowledged one; set beats clear
  always_ff @(posedge wb_clk_in or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      rx_pending <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (done_q)      rx_pending <= 1'b1;
      else if (rx_ack) rx_pending <= 1'b0;
      if (done_q && rx_pending && !rx_ack) overrun <= 1'b1;
      else if (overrun_clr)                 overrun <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_spi_slave_shift_register.sv
// Directed bench for spi_slave_shift_register.
// Drives an SPI master model on the pins and checks each scenario.
module tb_spi_slave_shift_register;

  localparam int H = 8;

  logic        wb_clk_in = 1'b0;
  logic        wb_rst_n;
  logic        enable, cpol, cpha, lsb;
  logic [4:0]  len;
  logic [31:0] tx_data;
  logic        tx_load;
  logic        sclk, ss_n, mosi;
  logic        miso, rx_valid, tx_ready, busy;
  logic [31:0] rx_data;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic        rx_ack, overrun_clr, overrun;
  logic        ov_seen = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int vcnt  = 0;

  spi_slave_shift_register dut (
    .wb_clk_in  (wb_clk_in),
    .wb_rst_n   (wb_rst_n),
    .enable     (enable),
    .cpol       (cpol),
    .cpha       (cpha),
    .lsb        (lsb),
    .len        (len),
    .tx_data    (tx_data),
    .tx_load    (tx_load),
`ifdef SPI_SLAVE_OVERRUN_EN
    .rx_ack     (rx_ack),
    .overrun_clr(overrun_clr),
    .overrun    (overrun),
`endif
    .sclk       (sclk),
    .ss_n       (ss_n),
    .mosi       (mosi),
    .miso       (miso),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy)
  );

  always #5 wb_clk_in = ~wb_clk_in;

  always @(negedge wb_clk_in) begin
    if (rx_valid === 1'b1) vcnt++;
`ifdef SPI_SLAVE_OVERRUN_EN
    if (rx_valid === 1'b1) ov_seen = overrun;
`endif
  end

  task automatic wclk(input int n);
    repeat (n) @(posedge wb_clk_in);
    #1;
  endtask

  task automatic load_tx(input logic [31:0] d);
    tx_data = d;
    tx_load = 1'b1;
    wclk(1);
    tx_load = 1'b0;
  endtask

  task automatic idle_mode(input logic p, input logic a,
                           input logic l, input logic [4:0] ln);
    cpol = p;
    cpha = a;
    lsb  = l;
    len  = ln;
    sclk = p;
    wclk(H);
  endtask

  // master: n-bit character, only the first nb bits are clocked
  task automatic master_char(input int n, input int nb,
                             input logic [31:0] mo,
                             output logic [31:0] mi);
    mi = '0;
    for (int b = 0; b < nb; b++) begin
      int bi;
      bi = lsb ? b : n - 1 - b;
      if (!cpha) begin
        mosi = mo[bi];
        wclk(H);
        mi[bi] = miso;
        sclk = ~cpol;
        wclk(H);
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = mo[bi];
        wclk(H);
        mi[bi] = miso;
        sclk = cpol;
        wclk(H);
      end
    end
    wclk(H);
  endtask

  task automatic test_reset();
    wclk(3);
    n_cmp++;
    if (miso !== 1'b0) begin
      n_bad++; $display("FAIL rst_miso got %b want 0", miso);
    end
    n_cmp++;
    if (rx_data !== 32'h0) begin
      n_bad++; $display("FAIL rst_rx_data got %h want 0", rx_data);
    end
    n_cmp++;
    if (rx_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_rx_valid got %b want 0", rx_valid);
    end
    n_cmp++;
    if (tx_ready !== 1'b1) begin
      n_bad++; $display("FAIL rst_tx_ready got %b want 1", tx_ready);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL rst_busy got %b want 0", busy);
    end
    wb_rst_n = 1'b1;
    wclk(2);
  endtask

  task automatic test_latency();
    int lat;
    int v0;
    idle_mode(1'b0, 1'b0, 1'b0, 5'd1);
    v0 = vcnt;
    ss_n = 1'b0;
    wclk(H);
    mosi = 1'b1;
    wclk(H);
    sclk = 1'b1;
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge wb_clk_in);
      #1;
      if (rx_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    n_cmp++;
    if (lat !== 4) begin
      n_bad++; $display("FAIL lat_cycles got %0d want 4", lat);
    end
    sclk = 1'b0;
    wclk(H);
    ss_n = 1'b1;
    mosi = 1'b0;
    wclk(H);
    n_cmp++;
    if (rx_data !== 32'h1) begin
      n_bad++; $display("FAIL lat_rx_data got %h want 1", rx_data);
    end
    n_cmp++;
    if (vcnt !== v0 + 1) begin
      n_bad++; $display("FAIL lat_vcnt got %0d want %0d", vcnt, v0 + 1);
    end
  endtask

  task automatic test_mode0();
    logic [31:0] mi;
    int v0;
    idle_mode(1'b0, 1'b0, 1'b0, 5'd8);
    v0 = vcnt;
    load_tx(32'hA5);
    n_cmp++;
    if (tx_ready !== 1'b0) begin
      n_bad++; $display("FAIL m0_ready_load got %b want 0", tx_ready);
    end
    ss_n = 1'b0;
    wclk(H);
    n_cmp++;
    if (busy !== 1'b1 || tx_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL m0_start got busy=%b rdy=%b want 1 1", busy, tx_ready);
    end
    master_char(8, 8, 32'h3C, mi);
    ss_n = 1'b1;
    wclk(H);
    n_cmp++;
    if (rx_data !== 32'h3C) begin
      n_bad++; $display("FAIL m0_rx_data got %h want 3c", rx_data);
    end
    n_cmp++;
    if (mi !== 32'hA5) begin
      n_bad++; $display("FAIL m0_miso got %h want a5", mi);
    end
    n_cmp++;
    if (vcnt !== v0 + 1) begin
      n_bad++; $display("FAIL m0_vcnt got %0d want %0d", vcnt, v0 + 1);
    end
  endtask

  task automatic test_abort();
    logic [31:0] mi;
    int v0;
    idle_mode(1'b0, 1'b0, 1'b0, 5'd8);
    v0 = vcnt;
    ss_n = 1'b0;
    wclk(H);
    master_char(8, 5, 32'hFF, mi);
    ss_n = 1'b1;
    wclk(H);
    n_cmp++;
    if (vcnt !== v0) begin
      n_bad++; $display("FAIL ab_vcnt got %0d want %0d", vcnt, v0);
    end
    n_cmp++;
    if (rx_data !== 32'h3C) begin
      n_bad++; $display("FAIL ab_rx_data got %h want 3c", rx_data);
    end
    n_cmp++;
    if (busy !== 1'b0 || miso !== 1'b0) begin
      n_bad++;
      $display("FAIL ab_idle got busy=%b miso=%b want 0 0", busy, miso);
    end
    ss_n = 1'b0;
    wclk(H);
    master_char(8, 8, 32'h96, mi);
    ss_n = 1'b1;
    wclk(H);
    n_cmp++;
    if (rx_data !== 32'h96) begin
      n_bad++; $display("FAIL ab_next_rx got %h want 96", rx_data);
    end
    n_cmp++;
    if (mi !== 32'hA5) begin
      n_bad++; $display("FAIL ab_resend got %h want a5", mi);
    end
    n_cmp++;
    if (vcnt !== v0 + 1) begin
      n_bad++; $display("FAIL ab_next_vcnt got %0d want %0d", vcnt, v0 + 1);
    end
  endtask

  task automatic test_mode3();
    logic [31:0] mi;
    int v0;
    idle_mode(1'b1, 1'b1, 1'b1, 5'd0);
    v0 = vcnt;
    load_tx(32'h12345678);
    ss_n = 1'b0;
    wclk(H);
    master_char(32, 32, 32'hDEADBEEF, mi);
    ss_n = 1'b1;
    wclk(H);
    n_cmp++;
    if (rx_data !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL m3_rx_data got %h want deadbeef", rx_data);
    end
    n_cmp++;
    if (mi !== 32'h12345678) begin
      n_bad++; $display("FAIL m3_miso got %h want 12345678", mi);
    end
    n_cmp++;
    if (vcnt !== v0 + 1) begin
      n_bad++; $display("FAIL m3_vcnt got %0d want %0d", vcnt, v0 + 1);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] mi;
    int v0;
    idle_mode(1'b0, 1'b0, 1'b0, 5'd8);
    v0 = vcnt;
    load_tx(32'h11);
    n_cmp++;
    if (tx_ready !== 1'b0) begin
      n_bad++; $display("FAIL b2b_rdy_load1 got %b want 0", tx_ready);
    end
    ss_n = 1'b0;
    wclk(H);
    n_cmp++;
    if (tx_ready !== 1'b1) begin
      n_bad++; $display("FAIL b2b_rdy_start got %b want 1", tx_ready);
    end
    load_tx(32'h22);
    n_cmp++;
    if (tx_ready !== 1'b0) begin
      n_bad++; $display("FAIL b2b_rdy_load2 got %b want 0", tx_ready);
    end
    master_char(8, 8, 32'h5A, mi);
    n_cmp++;
    if (tx_ready !== 1'b1) begin
      n_bad++; $display("FAIL b2b_rdy_reload got %b want 1", tx_ready);
    end
    n_cmp++;
    if (rx_data !== 32'h5A) begin
      n_bad++; $display("FAIL b2b_rx1 got %h want 5a", rx_data);
    end
    n_cmp++;
    if (mi !== 32'h11) begin
      n_bad++; $display("FAIL b2b_miso1 got %h want 11", mi);
    end
    master_char(8, 8, 32'hC3, mi);
    ss_n = 1'b1;
    wclk(H);
    n_cmp++;
    if (rx_data !== 32'hC3) begin
      n_bad++; $display("FAIL b2b_rx2 got %h want c3", rx_data);
    end
    n_cmp++;
    if (mi !== 32'h22) begin
      n_bad++; $display("FAIL b2b_miso2 got %h want 22", mi);
    end
    n_cmp++;
    if (vcnt !== v0 + 2) begin
      n_bad++; $display("FAIL b2b_vcnt got %0d want %0d", vcnt, v0 + 2);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] mi;
    int v0;
    idle_mode(1'b0, 1'b0, 1'b0, 5'd8);
    ss_n = 1'b0;
    wclk(H);
    master_char(8, 3, 32'hF0, mi);
    #3;
    wb_rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rx_data !== 32'h0 || rx_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rm_rx got %h/%b want 0/0", rx_data, rx_valid);
    end
    n_cmp++;
    if (busy !== 1'b0 || miso !== 1'b0) begin
      n_bad++;
      $display("FAIL rm_idle got busy=%b miso=%b want 0 0", busy, miso);
    end
    n_cmp++;
    if (tx_ready !== 1'b1) begin
      n_bad++; $display("FAIL rm_tx_ready got %b want 1", tx_ready);
    end
    ss_n = 1'b1;
    sclk = 1'b0;
    wclk(3);
    wb_rst_n = 1'b1;
    wclk(H);
    v0 = vcnt;
    for (int k = 0; k < 8; k++) begin
      sclk = 1'b1;
      wclk(H);
      sclk = 1'b0;
      wclk(H);
    end
    n_cmp++;
    if (vcnt !== v0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rm_quiet got vcnt=%0d busy=%b want %0d 0",
               vcnt, busy, v0);
    end
  endtask

`ifdef SPI_SLAVE_OVERRUN_EN
  task automatic test_overrun();
    logic [31:0] mi;
    idle_mode(1'b0, 1'b0, 1'b0, 5'd8);
    ss_n = 1'b0;
    wclk(H);
    master_char(8, 8, 32'h01, mi);
    master_char(8, 8, 32'h02, mi);
    ss_n = 1'b1;
    wclk(H);
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_bad++; $display("FAIL ov_set got %b want 1", overrun);
    end
    overrun_clr = 1'b1;
    wclk(1);
    overrun_clr = 1'b0;
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_bad++; $display("FAIL ov_clr got %b want 0", overrun);
    end
    ov_seen = 1'b0;
    overrun_clr = 1'b1;
    ss_n = 1'b0;
    wclk(H);
    master_char(8, 8, 32'h03, mi);
    ss_n = 1'b1;
    overrun_clr = 1'b0;
    wclk(H);
    n_cmp++;
    if (ov_seen !== 1'b1) begin
      n_bad++; $display("FAIL ov_set_wins got %b want 1", ov_seen);
    end
  endtask
`endif

  initial begin
    wb_rst_n = 1'b0;
    enable   = 1'b1;
    cpol     = 1'b0;
    cpha     = 1'b0;
    lsb      = 1'b0;
    len      = 5'd8;
    tx_data  = '0;
    tx_load  = 1'b0;
    sclk     = 1'b0;
    ss_n     = 1'b1;
    mosi     = 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
    rx_ack      = 1'b0;
    overrun_clr = 1'b0;
`endif
    test_reset();
    test_latency();
    test_mode0();
    test_abort();
    test_mode3();
    test_back_to_back();
    test_reset_mid();
`ifdef SPI_SLAVE_OVERRUN_EN
    test_overrun();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_shift_register.md
Name: spi_slave_shift_register

Overview:
SPI slave-side shift engine: the counterpart of the master shift register. It receives sclk/ss_n/mosi from an external master and drives miso. All logic runs on wb_clk_in; the SPI pins are oversampled through synchronisers. It presents whole received characters on a parallel bus with a one-cycle valid strobe, and accepts the next transmit character through a holding register.

Parameters:
MAX_CHAR, 32 (`SPI_MAX_CHAR), maximum character length in bits
CHAR_LEN_BITS, 5 (`SPI_CHAR_LEN_BITS), width of len
SYNC_STAGES, 2, synchroniser flops on sclk, ss_n and mosi (minimum 2)

Ports:
wb_clk_in  in  1  system clock; only clock in the block
wb_rst_n  in  1  asynchronous, active-low reset
enable  in  1  block enable; 0 = ignore pins, hold idle
cpol  in  1  sclk idle level
cpha  in  1  0 = sample on leading edge; 1 = sample on trailing edge
lsb  in  1  1 = LSB first; 0 = MSB first
len  in  CHAR_LEN_BITS  character length; 0 encodes MAX_CHAR
tx_data  in  MAX_CHAR  next transmit character
tx_load  in  1  write tx_data into the holding register
sclk  in  1  SPI clock from master (asynchronous)
ss_n  in  1  slave select, active low (asynchronous)
mosi  in  1  serial data from master (asynchronous)
miso  out  1  serial data to master
rx_data  out  MAX_CHAR  last completed received character
rx_valid  out  1  one-cycle pulse when rx_data updates
tx_ready  out  1  holding register is free for tx_load
busy  out  1  character in progress (ss_n low and bits are pending)

Behaviour:
- Reset values: miso=0, rx_data=0, rx_valid=0, tx_ready=1, busy=0, holding register=0, bit counter=0. Synchronisers reset to sclk=cpol-independent 0, ss_n=1, mosi=0.
- Edge detection: sclk is edge-detected after synchronising, using the synced value and one delayed copy. The leading edge is a transition away from cpol; the trailing edge is a transition back to cpol. Sample edge = leading if cpha=0, trailing if cpha=1; shift edge = the other one.
- Effective length N = {~|len, len} (CHAR_LEN_BITS+1 bits). Bit counter cnt is CHAR_LEN_BITS+1 bits wide.
- Start condition: synced ss_n falls while enable=1. On that cycle: cnt<=N; the tx shift register loads from the holding register; tx_ready<=1; busy<=1. miso is driven with the first bit on the next cycle, so the first bit is valid before the first cpha=0 sample edge.
- Bit index: MSB-first, idx = cnt-1; LSB-first, idx = N-cnt.
- Sample edge while busy: rx_shift[idx] <= synced mosi; cnt<=cnt-1.
- Shift edge while busy: miso <= tx_shift[new idx]. When cpha=1, the first leading edge drives bit 0 of the sequence and does not advance the index.
- Character complete: the sample edge at cnt=1. rx_data <= assembled word, with bits at and above N forced to 0. rx_valid pulses on the next cycle. If ss_n is still low: cnt<=N, tx_shift reloads from the holding register, tx_ready<=1 (back-to-back characters).
- Holding register: tx_load when tx_ready=1 writes it and sets tx_ready=0. tx_load while tx_ready=0 overwrites the data, and the last write wins. If no load occurred, the previous holding value is resent.
- tx_load and a reload on the same cycle: the shift register takes the old holding value; the new value lands in the holding register and tx_ready=0.
- ss_n rising mid-character: abort. busy<=0, cnt<=0, no rx_valid, rx_data unchanged, miso<=0.
- enable=0: same as abort; pin activity is ignored.
- Latency: rx_valid asserts SYNC_STAGES+2 wb_clk_in cycles after the final sampling sclk edge at the pin.
- Timing constraint (not checked in RTL): sclk half-period ≥ SYNC_STAGES+2 wb_clk_in cycles.
- Reset mid-character: immediate return to reset values. The character is lost.

Optional Feature:
SPI_SLAVE_OVERRUN_EN: adds output port overrun (1 bit, reset 0) and input overrun_clr.
- overrun sets when a character completes while the previous rx_data has not been acknowledged. Acknowledgement is rx_ack (1 bit input, added by the same macro).
- overrun clears on overrun_clr. If set and clear happen together, set wins.
- rx_data is still overwritten.
Without the macro: no overrun, overrun_clr or rx_ack ports, and no tracking logic.

Decomposition:
- Shared package/include spi_define.v: SPI_MAX_CHAR, SPI_CHAR_LEN_BITS, edge-select encodings.
- One sub-module, spi_slave_sync_edge: a SYNC_STAGES synchroniser plus rise/fall detector. It is instantiated for sclk, ss_n and mosi; the mosi instance uses the synced output only.

Test Plan:
- Mode 0, MSB-first, len=8, tx holding 0xA5, master sends 0x3C → rx_data=0x3C with one rx_valid pulse; master captures 0xA5.
- Mode 3, LSB-first, len=0 (32 bits), master sends 0xDEADBEEF, tx 0x12345678 → rx_data=0xDEADBEEF; master sees 0x12345678 in LSB-first order.
- Back-to-back: two 8-bit characters under one ss_n low, tx_load 0x11 then 0x22 between them → rx_valid twice; miso sequence 0x11, 0x22; tx_ready toggles 0→1 at each reload.
- Abort: ss_n rises after 5 of 8 bits → no rx_valid, rx_data unchanged, busy=0, miso=0; the next full char is received correctly.
- Reset asserted mid-character → all outputs at reset values within the same cycle; no rx_valid after release until a new ss_n fall.
- With SPI_SLAVE_OVERRUN_EN: two chars with no rx_ack → overrun=1 after the second; overrun_clr → 0; clr with a simultaneous set → remains 1.
